// File: rtl/ttt_step_sequencer_pkg.sv
// rtl/ttt_step_sequencer_pkg.sv - shared widths, op codes, states and helpers for the step sequencer
package ttt_pkg;

  localparam int TTT_CNT_BITS      = 7;
  localparam int TTT_STEP_CNT_BITS = 16;
  localparam int TTT_OP_BITS       = 4;
  localparam int TTT_DATA_BITS     = 8;

  localparam logic [3:0] OP_ADD_GOOD  = 4'b0000;
  localparam logic [3:0] OP_ADD_BAD   = 4'b0001;
  localparam logic [3:0] OP_TALLY     = 4'b1000;
  localparam logic [3:0] OP_COUNTDOWN = 4'b1001;
  localparam logic [3:0] OP_SET_GTH   = 4'b1010;
  localparam logic [3:0] OP_SET_BTH   = 4'b1100;
  localparam logic [3:0] OP_SET_DUR   = 4'b1110;
  // Adding zero good tokens leaves the processor untouched, so it doubles as the idle op
  localparam logic [3:0] OP_NOP       = OP_ADD_GOOD;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GOOD    = 3'd1;
  localparam logic [2:0] S_BAD     = 3'd2;
  localparam logic [2:0] S_TALLY   = 3'd3;
  localparam logic [2:0] S_CDOWN   = 3'd4;
  localparam logic [2:0] S_CAPT    = 3'd5;
  localparam logic [2:0] S_CFG     = 3'd6;
  localparam logic [2:0] S_CFG_CHK = 3'd7;

  typedef enum logic [1:0] {
    CFG_GTH  = 2'd0,
    CFG_BTH  = 2'd1,
    CFG_DUR  = 2'd2,
    CFG_RSVD = 2'd3
  } cfg_sel_e;

  localparam int RESP_ST = 1;
  localparam int RESP_SP = 0;

  function automatic logic [3:0] ttt_op_encode(input logic [1:0] sel);
    case (sel)
      CFG_GTH: ttt_op_encode = OP_SET_GTH;
      CFG_BTH: ttt_op_encode = OP_SET_BTH;
      CFG_DUR: ttt_op_encode = OP_SET_DUR;
      default: ttt_op_encode = OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/ttt_step_sequencer_if.sv
// rtl/ttt_step_sequencer_if.sv - host-side step/config/result handshakes of the step sequencer
interface ttt_step_sequencer_if #(
  parameter int CNT_BITS  = ttt_pkg::TTT_CNT_BITS,
  parameter int DATA_BITS = ttt_pkg::TTT_DATA_BITS
);
  logic                 step_valid;
  logic                 step_ready;
  logic [CNT_BITS-1:0]  step_good;
  logic [CNT_BITS-1:0]  step_bad;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [1:0]           cfg_sel;
  logic [DATA_BITS-1:0] cfg_data;
  logic                 res_valid;
  logic                 res_ready;
  logic                 res_start;
  logic                 res_stop;

  modport master (
    output step_valid, step_good, step_bad, cfg_valid, cfg_sel, cfg_data, res_ready,
    input  step_ready, cfg_ready, res_valid, res_start, res_stop
  );

  modport slave (
    input  step_valid, step_good, step_bad, cfg_valid, cfg_sel, cfg_data, res_ready,
    output step_ready, cfg_ready, res_valid, res_start, res_stop
  );
endinterface

// File: rtl/ttt_step_sequencer.sv
// rtl/ttt_step_sequencer.sv - sequences one ticktocktokens processor through timesteps and parameter writes
module ttt_step_sequencer
  import ttt_pkg::*;
#(
  parameter int CNT_BITS      = TTT_CNT_BITS,
  parameter int STEP_CNT_BITS = TTT_STEP_CNT_BITS,
  parameter int OP_BITS       = TTT_OP_BITS,
  parameter int DATA_BITS     = TTT_DATA_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ttt_step_sequencer_if.slave      bus,
  output logic                     cfg_err,
  output logic [STEP_CNT_BITS-1:0] steps_done,
  output logic                     busy,
  output logic [OP_BITS-1:0]       proc_instr,
  output logic [DATA_BITS-1:0]     proc_data,
  input  logic [DATA_BITS-1:0]     proc_resp
);

  logic [2:0]           state, state_nxt;
  logic [OP_BITS-1:0]   op_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic [CNT_BITS-1:0]  bad_q;
  logic [DATA_BITS-1:0] cfg_q;
  logic                 tally_st, tally_sp;
  logic                 res_valid_q, res_start_q, res_stop_q;
  logic                 idle_free, accept_cfg, accept_step;

  assign idle_free   = (state == S_IDLE) && !res_valid_q;
  assign accept_cfg  = idle_free && bus.cfg_valid;
  assign accept_step = idle_free && !bus.cfg_valid && bus.step_valid;

  assign bus.step_ready = idle_free;
  assign bus.cfg_ready  = idle_free;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_start  = res_start_q;
  assign bus.res_stop   = res_stop_q;
  assign busy           = (state != S_IDLE);

  // Bus outputs are registered from the next state, so the op is on the bus while its state is current
  always_comb begin
    state_nxt = state;
    op_nxt    = OP_NOP;
    data_nxt  = '0;
    case (state)
      S_IDLE: begin
        if (accept_cfg) begin
          if (bus.cfg_sel != CFG_RSVD) begin
            state_nxt = S_CFG;
            op_nxt    = ttt_op_encode(bus.cfg_sel);
            data_nxt  = bus.cfg_data;
          end
        end else if (accept_step) begin
          if (bus.step_good != '0) begin
            state_nxt = S_GOOD;
            op_nxt    = OP_ADD_GOOD;
            data_nxt  = DATA_BITS'(bus.step_good);
          end else if (bus.step_bad != '0) begin
            state_nxt = S_BAD;
            op_nxt    = OP_ADD_BAD;
            data_nxt  = DATA_BITS'(bus.step_bad);
          end else begin
            state_nxt = S_TALLY;
            op_nxt    = OP_TALLY;
          end
        end
      end
      S_GOOD: begin
        if (bad_q != '0) begin
          state_nxt = S_BAD;
          op_nxt    = OP_ADD_BAD;
          data_nxt  = DATA_BITS'(bad_q);
        end else begin
          state_nxt = S_TALLY;
          op_nxt    = OP_TALLY;
        end
      end
      S_BAD: begin
        state_nxt = S_TALLY;
        op_nxt    = OP_TALLY;
      end
      S_TALLY: begin
        state_nxt = S_CDOWN;
        op_nxt    = OP_COUNTDOWN;
      end
      S_CDOWN:   state_nxt = S_CAPT;
      S_CAPT:    state_nxt = S_IDLE;
      S_CFG:     state_nxt = S_CFG_CHK;
      S_CFG_CHK: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      proc_instr  <= OP_NOP;
      proc_data   <= '0;
      bad_q       <= '0;
      cfg_q       <= '0;
      tally_st    <= 1'b0;
      tally_sp    <= 1'b0;
      res_valid_q <= 1'b0;
      res_start_q <= 1'b0;
      res_stop_q  <= 1'b0;
      cfg_err     <= 1'b0;
      steps_done  <= '0;
    end else begin
      state      <= state_nxt;
      proc_instr <= op_nxt;
      proc_data  <= data_nxt;
      if (accept_step) bad_q <= bus.step_bad;
      if (accept_cfg)  cfg_q <= bus.cfg_data;
      // proc_resp lags the issued op by one cycle: tally answers in CDOWN, countdown in CAPT
      if (state == S_CDOWN) begin
        tally_st <= proc_resp[RESP_ST];
        tally_sp <= proc_resp[RESP_SP];
      end
      if (state == S_CAPT) begin
        res_valid_q <= 1'b1;
        res_start_q <= tally_st;
        res_stop_q  <= tally_sp | proc_resp[RESP_SP];
        steps_done  <= steps_done + STEP_CNT_BITS'(1);
      end else if (res_valid_q && bus.res_ready) begin
        res_valid_q <= 1'b0;
      end
      if (state == S_CFG_CHK && proc_resp != cfg_q) cfg_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ttt_step_sequencer.sv
// tb/tb_ttt_step_sequencer.sv - self-checking bench for ttt_step_sequencer with a processor model
module tb_ttt_step_sequencer;
  import ttt_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_err, busy;
  logic [15:0] steps_done;
  logic [3:0]  proc_instr;
  logic [7:0]  proc_data, proc_resp;

  always #5 clk = ~clk;

  ttt_step_sequencer_if bus();

  ttt_step_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .cfg_err    (cfg_err),
    .steps_done (steps_done),
    .busy       (busy),
    .proc_instr (proc_instr),
    .proc_data  (proc_data),
    .proc_resp  (proc_resp)
  );

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  tally_r = 8'h00;
  logic [7:0]  cdown_r = 8'h00;
  bit          corrupt = 1'b0;
  logic [11:0] bus_log[$];
  int          model_steps = 0;
  bit          model_err = 1'b0;

  // Processor: answers one cycle after each op; set ops echo their data (optionally off by one)
  always @(posedge clk) begin
    case (proc_instr)
      OP_TALLY:                           proc_resp <= tally_r;
      OP_COUNTDOWN:                       proc_resp <= cdown_r;
      OP_SET_GTH, OP_SET_BTH, OP_SET_DUR: proc_resp <= proc_data + 8'(corrupt);
      default:                            proc_resp <= 8'($urandom);
    endcase
  end

  always @(negedge clk)
    if (proc_instr != 4'b0000 || proc_data != 8'h00) bus_log.push_back({proc_instr, proc_data});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_result(input int exp_lat);
    bit got = 1'b0;
    int lat = 0;
    for (int i = 1; i <= 12 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.res_valid) begin
        got = 1'b1;
        lat = i;
      end
    end
    check("latency", lat, exp_lat);
  endtask

  task automatic check_result(input logic [11:0] exp_q[$], input logic [7:0] t, input logic [7:0] c,
                              input int hold);
    model_steps = (model_steps + 1) & 32'hFFFF;
    check("res_start", bus.res_start, t[1]);
    check("res_stop", bus.res_stop, t[0] | c[0]);
    check("steps_done", steps_done, model_steps);
    check("cfg_err", cfg_err, model_err);
    check("bus_len", bus_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < bus_log.size(); i++) check("bus_op", bus_log[i], exp_q[i]);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", bus.res_valid, 1);
      check("hold_start", bus.res_start, t[1]);
      check("hold_stop", bus.res_stop, t[0] | c[0]);
      check("hold_ready", bus.step_ready, 0);
      check("hold_bus", {proc_instr, proc_data}, 0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check("res_clear", bus.res_valid, 0);
    check("idle", busy, 0);
  endtask

  task automatic do_step(input logic [6:0] g, input logic [6:0] b, input logic [7:0] t,
                         input logic [7:0] c, input int hold);
    logic [11:0] exp_q[$];
    if (g != 0) exp_q.push_back({OP_ADD_GOOD, 1'b0, g});
    if (b != 0) exp_q.push_back({OP_ADD_BAD, 1'b0, b});
    exp_q.push_back({OP_TALLY, 8'h00});
    exp_q.push_back({OP_COUNTDOWN, 8'h00});
    tally_r = t;
    cdown_r = c;
    @(negedge clk);
    bus_log.delete();
    bus.step_good  = g;
    bus.step_bad   = b;
    bus.step_valid = 1'b1;
    check("step_ready", bus.step_ready, 1);
    @(posedge clk); #1;
    bus.step_valid = 1'b0;
    wait_result(3 + int'(g != 0) + int'(b != 0));
    check_result(exp_q, t, c, hold);
  endtask

  task automatic do_cfg(input logic [1:0] sel, input logic [7:0] data, input bit bad_echo);
    corrupt = bad_echo;
    @(negedge clk);
    bus_log.delete();
    bus.cfg_sel   = sel;
    bus.cfg_data  = data;
    bus.cfg_valid = 1'b1;
    check("cfg_ready", bus.cfg_ready, 1);
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    if (sel != 2'd3) model_err = model_err | bad_echo;
    for (int i = 0; i < 6 && busy; i++) begin
      @(posedge clk); #1;
    end
    check("cfg_done", busy, 0);
    check("cfg_len", bus_log.size(), (sel == 2'd3) ? 0 : 1);
    if (sel != 2'd3 && bus_log.size() > 0) check("cfg_op", bus_log[0], {ttt_op_encode(sel), data});
    check("cfg_err", cfg_err, model_err);
    check("cfg_steps", steps_done, model_steps);
    check("cfg_res", bus.res_valid, 0);
    corrupt = 1'b0;
  endtask

  initial begin
    logic [11:0] exp_q[$];
    logic [6:0]  rg, rb;
    bit          accepted;
    rst_n          = 1'b0;
    bus.step_valid = 1'b0;
    bus.step_good  = '0;
    bus.step_bad   = '0;
    bus.cfg_valid  = 1'b0;
    bus.cfg_sel    = 2'd0;
    bus.cfg_data   = 8'h00;
    bus.res_ready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_instr", proc_instr, 0);
    check("rst_data", proc_data, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_flags", {bus.res_start, bus.res_stop}, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_steps", steps_done, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", bus.step_ready, 1);

    do_step(7'd5, 7'd3, 8'h02, 8'h00, 0);
    do_step(7'd0, 7'd0, 8'h00, 8'h01, 4);
    do_step(7'd0, 7'd9, 8'h03, 8'h00, 1);
    do_step(7'd127, 7'd0, 8'h01, 8'h00, 0);

    // Config and step requested together: config wins, step follows once idle
    tally_r = 8'h02;
    cdown_r = 8'h01;
    @(negedge clk);
    bus_log.delete();
    bus.cfg_sel    = 2'd2;
    bus.cfg_data   = 8'h2A;
    bus.cfg_valid  = 1'b1;
    bus.step_good  = 7'd4;
    bus.step_bad   = 7'd0;
    bus.step_valid = 1'b1;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    accepted = 1'b0;
    for (int i = 0; i < 8 && !accepted; i++) begin
      @(negedge clk);
      if (bus.step_ready) begin
        @(posedge clk); #1;
        bus.step_valid = 1'b0;
        accepted = 1'b1;
      end
    end
    bus.step_valid = 1'b0;
    check("prio_accept", accepted, 1);
    wait_result(4);
    exp_q = {};
    exp_q.push_back({OP_SET_DUR, 8'h2A});
    exp_q.push_back({OP_ADD_GOOD, 8'h04});
    exp_q.push_back({OP_TALLY, 8'h00});
    exp_q.push_back({OP_COUNTDOWN, 8'h00});
    check_result(exp_q, 8'h02, 8'h01, 0);

    do_cfg(2'd0, 8'h55, 1'b0);
    do_cfg(2'd1, 8'h00, 1'b0);
    do_cfg(2'd3, 8'h77, 1'b1);

    for (int n = 0; n < 24; n++) begin
      rg = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      rb = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      if (n % 6 == 5) do_cfg(2'($urandom_range(0, 2)), 8'($urandom), 1'b0);
      else do_step(rg, rb, 8'($urandom), 8'($urandom), $urandom_range(0, 3));
    end

    do_cfg(2'd2, 8'h2A, 1'b1);
    do_step(7'd1, 7'd2, 8'h00, 8'h00, 0);
    do_step(7'd0, 7'd0, 8'h02, 8'h00, 2);

    // Reset while TALLY is on the bus
    tally_r = 8'h02;
    @(negedge clk);
    bus.step_good  = 7'd5;
    bus.step_bad   = 7'd3;
    bus.step_valid = 1'b1;
    @(posedge clk); #1;
    bus.step_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("mid_tally", proc_instr, OP_TALLY);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_instr", proc_instr, 0);
    check("abort_busy", busy, 0);
    check("abort_res_valid", bus.res_valid, 0);
    check("abort_steps", steps_done, 0);
    check("abort_cfg_err", cfg_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_steps = 0;
    model_err   = 1'b0;
    do_step(7'd2, 7'd2, 8'h01, 8'h01, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
